// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up at the end.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Read_data1,
    input  logic [31:0] Read_data2,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic        Write_HI,
    input  logic        Write_LO,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_a;
    logic [63:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
        logic signed [31:0] sx;
        sx = x;
        if (is_signed && (sx < 0))
            return $unsigned(-sx);
        return x;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x, input logic neg);
        logic signed [31:0] sx;
        sx = x;
        return neg ? $unsigned(-sx) : x;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x, input logic neg);
        logic signed [63:0] sx;
        sx = x;
        return neg ? $unsigned(-sx) : x;
    endfunction

    logic        w_signed;
    logic        w_div;
    logic        w_div0;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rmd;

    assign w_signed = ~Op[0];
    assign w_div    = Op[1];
    assign w_div0   = w_div && (Read_data2 == 32'd0);
    assign w_mag_a  = magnitude(Read_data1, w_signed);
    assign w_mag_b  = magnitude(Read_data2, w_signed);

    // Multiply: the low half of r_acc holds the unconsumed multiplier bits.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_a} : 33'd0);

    // Divide: r_acc[31:0] shifts dividend bits out and quotient bits in.
    assign w_div_shift = {r_rem, r_acc[31]};
    assign w_div_trial = w_div_shift - {1'b0, r_a};

    assign w_prod = neg64(r_acc, r_neg_q);
    assign w_quot = neg32(r_acc[31:0], r_neg_q);
    assign w_rmd  = neg32(r_rem, r_neg_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= 32'd0;
            r_acc    <= 64'd0;
            r_rem    <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (Write_HI) r_hi <= Read_data1;
                if (Write_LO) r_lo <= Read_data1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        if (w_div0) begin
                            r_hi    <= Read_data1;
                            r_lo    <= 32'hFFFF_FFFF;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_is_div <= w_div;
                            r_neg_q  <= w_signed & (Read_data1[31] ^ Read_data2[31]);
                            r_neg_r  <= w_signed & Read_data1[31];
                            r_a      <= w_div ? w_mag_b : w_mag_a;
                            r_acc    <= {32'd0, (w_div ? w_mag_a : w_mag_b)};
                            r_rem    <= 32'd0;
                            r_cnt    <= 5'd0;
                            r_busy   <= 1'b1;
                            r_state  <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        // Trial borrow in bit 32 means the divisor did not fit: restore.
                        r_rem        <= w_div_trial[32] ? w_div_shift[31:0] : w_div_trial[31:0];
                        r_acc[31:0]  <= {r_acc[30:0], ~w_div_trial[32]};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[31:1]};
                    end
                    if (r_cnt == 5'd31)
                        r_state <= S_SIGN;
                    else
                        r_cnt <= r_cnt + 5'd1;
                end
                S_SIGN: begin
                    if (r_is_div) begin
                        r_hi <= w_rmd;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level behavioural model plus directed vectors.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Read_data1 = 32'd0;
    logic [31:0] Read_data2 = 32'd0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'd0;
    logic        Write_HI = 1'b0;
    logic        Write_LO = 1'b0;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;

    int n_pass = 0;
    int n_total = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .Read_data1(Read_data1),
        .Read_data2(Read_data2),
        .Start     (Start),
        .Op        (Op),
        .Write_HI  (Write_HI),
        .Write_LO  (Write_LO),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Architectural result of one operation from plain 64-bit arithmetic.
    task automatic compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] rh, output logic [31:0] rl, output logic dz);
        logic signed [63:0] sa, sb, sr;
        logic [63:0] ua, ub, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        dz = 1'b0;
        rh = 32'd0;
        rl = 32'd0;
        if (op[1] && b == 32'd0) begin
            dz = 1'b1;
            rh = a;
            rl = 32'hFFFF_FFFF;
        end else begin
            case (op)
                2'd0: begin sr = sa * sb; rh = sr[63:32]; rl = sr[31:0]; end
                2'd1: begin ur = ua * ub; rh = ur[63:32]; rl = ur[31:0]; end
                2'd2: begin sr = sa / sb; rl = sr[31:0]; sr = sa % sb; rh = sr[31:0]; end
                default: begin ur = ua / ub; rl = ur[31:0]; ur = ua % ub; rh = ur[31:0]; end
            endcase
        end
    endtask

    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_res_hi = 32'd0, m_res_lo = 32'd0;
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk or posedge reset) begin : model
        logic [31:0] rh, rl;
        logic        dz;
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (Write_HI) m_hi = Read_data1;
                if (Write_LO) m_lo = Read_data1;
            end
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_res_hi; m_lo = m_res_lo; m_busy = 1'b0; m_done = 1'b1;
                end
            end else if (Start) begin
                compute(Op, Read_data1, Read_data2, rh, rl, dz);
                if (dz) begin
                    m_hi = rh; m_lo = rl; m_done = 1'b1;
                end else begin
                    m_res_hi = rh; m_res_lo = rl; m_left = 33; m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_HI", HI, m_hi);
            chk("cyc_LO", LO, m_lo);
            chk("cyc_Busy", {31'd0, Busy}, {31'd0, m_busy});
            chk("cyc_Done", {31'd0, Done}, {31'd0, m_done});
        end
    end

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic whi);
        @(negedge clk);
        Op = op; Read_data1 = a; Read_data2 = b; Start = 1'b1; Write_HI = whi;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; Write_HI = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int busy_cyc);
        edges = 1;
        busy_cyc = Busy ? 1 : 0;
        while (!Done && edges < 60) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (Busy) busy_cyc++;
        end
        if (!Done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int elat, input int ebusy);
        int e, bc;
        launch(op, a, b, 1'b0);
        wait_done(e, bc);
        chk({name, "_HI"}, HI, eh);
        chk({name, "_LO"}, LO, el);
        chk({name, "_model_HI"}, m_hi, eh);
        chk({name, "_model_LO"}, m_lo, el);
        chk({name, "_latency"}, e, elat);
        chk({name, "_busy_cycles"}, bc, ebusy);
    endtask

    initial begin : stim
        int e, bc;
        repeat (2) @(negedge clk);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_Busy", {31'd0, Busy}, 32'd0);
        chk("rst_Done", {31'd0, Done}, 32'd0);
        reset = 1'b0;

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 33);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 33);
        run_op("mult_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 33);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33);
        run_op("divu", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34, 33);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 33);
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1, 0);
        @(negedge clk);
        chk("div0_after_Busy", {31'd0, Busy}, 32'd0);
        chk("div0_after_Done", {31'd0, Done}, 32'd0);

        // Start and MTLO during a busy MULTU are both dropped.
        launch(2'd1, 32'd3, 32'd4, 1'b0);
        repeat (8) @(negedge clk);
        Start = 1'b1; Op = 2'd0; Read_data1 = 32'h1234; Read_data2 = 32'd9; Write_LO = 1'b1;
        @(negedge clk);
        Start = 1'b0; Write_LO = 1'b0;
        chk("busy_mtlo_ignored", LO, 32'hFFFF_FFFF);
        wait_done(e, bc);
        chk("ignore_HI", HI, 32'd0);
        chk("ignore_LO", LO, 32'd12);

        @(negedge clk);
        Write_LO = 1'b1; Read_data1 = 32'h1234;
        @(posedge clk);
        #1 chk("idle_mtlo", LO, 32'h1234);
        @(negedge clk);
        Write_LO = 1'b0;

        // MTHI together with a DIV launch, then reset mid-division.
        launch(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        chk("launch_mthi", HI, 32'hFFFF_FFF9);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_HI", HI, 32'd0);
        chk("abort_LO", LO, 32'd0);
        chk("abort_Busy", {31'd0, Busy}, 32'd0);
        chk("abort_Done", {31'd0, Done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("post_rst", 2'd1, 32'd2, 32'd2, 32'd0, 32'd4, 34, 33);

        // Back-to-back: Start held high through DONE relaunches at once.
        @(negedge clk);
        Op = 2'd1; Read_data1 = 32'd3; Read_data2 = 32'd5; Start = 1'b1;
        e = 0;
        do begin
            @(posedge clk); e++;
            @(negedge clk);
        end while (!Done && e < 60);
        chk("b2b_first_edge", e, 34);
        chk("b2b_first_LO", LO, 32'd15);
        Read_data1 = 32'd6; Read_data2 = 32'd7;
        @(posedge clk); e++;
        @(negedge clk);
        Start = 1'b0;
        chk("b2b_relaunch_busy", {31'd0, Busy}, 32'd1);
        while (!Done && e < 120) begin
            @(posedge clk); e++;
            @(negedge clk);
        end
        chk("b2b_second_edge", e, 68);
        chk("b2b_second_LO", LO, 32'd42);
        chk("b2b_second_HI", HI, 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit for the MIPS 32-bit datapath, with HI/LO result registers. It consumes the two register-bank read operands (Read_data1, Read_data2) in the execute stage and runs MULT, MULTU, DIV and DIVU iteratively. HI/LO are readable at any time; the writeback path routes them to the register bank's Write_Data for MFHI/MFLO. Control stalls issue while Busy is high.

## Interface

- No parameters. Width is fixed at 32 bits and iteration count at 32.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Read_data1  input  32  operand A: multiplicand or dividend (rs).
- Read_data2  input  32  operand B: multiplier or divisor (rt).
- Start  input  1  launch request; sampled on the rising edge.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Write_HI  input  1  MTHI: load HI from Read_data1.
- Write_LO  input  1  MTLO: load LO from Read_data1.
- HI  output  32  HI register: product high word, or remainder.
- LO  output  32  LO register: product low word, or quotient.
- Busy  output  1  high while an operation is in progress (CALC or SIGN).
- Done  output  1  one-cycle pulse; HI/LO hold the new result.

## Operation

- Reset values: HI=0, LO=0, Busy=0, Done=0, state IDLE, iteration counter 0.
- States:
  - IDLE: waiting for Start.
  - CALC: one iteration per cycle, 32 cycles total.
  - SIGN: applies sign correction and writes HI/LO.
  - DONE: raises Done for one cycle.
- Transitions:
  - IDLE or DONE with Start=1 goes to CALC. Operands, Op and the sign flags are latched, and the counter is cleared.
  - Exception: a division with Read_data2=0 goes straight to DONE.
  - CALC goes to SIGN when the counter reaches 31. Otherwise it stays in CALC and the counter increments.
  - SIGN goes to DONE.
  - DONE with Start=0 goes to IDLE.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at launch. 0x80000000 gives magnitude 2^31, which is representable unsigned.
  - Product sign is signA XOR signB; the 64-bit result is two's-complement negated if set.
  - Quotient sign is signA XOR signB.
  - Remainder sign is signA.
- Multiply: shift-add, one multiplier bit per cycle, with a 64-bit accumulator. HI receives bits [63:32], LO receives bits [31:0].
- Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder. LO receives the quotient, HI the remainder.
- Divide by zero (DIV or DIVU with B=0): LO=0xFFFFFFFF, HI=Read_data1 unmodified. These are written on the launch edge.
- Overflow (DIV of 0x80000000 by 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of the magnitude/negate rule; no special case is needed.
- Write_HI / Write_LO:
  - Honoured only when Busy=0.
  - Ignored while Busy=1; no error is flagged.
  - If asserted on the same edge as an accepted Start, the move is applied first and the launch proceeds. The new result overwrites HI/LO later.
- Start while Busy=1 is ignored. The in-flight operation is not disturbed.
- Op values are all legal; there is no illegal encoding.

## Timing

- Call the edge that accepts Start edge 0.
  - Edges 1 to 32: CALC iterations. Busy=1 from edge 0 until edge 33.
  - Edge 33: SIGN writes HI/LO. Busy falls.
  - Edge 33 to edge 34: DONE, Done=1.
  - Edge 34: return to IDLE.
- Latency: Start to Done is 34 cycles. HI/LO change only at edge 33.
- Back-to-back: Start held high in DONE relaunches at edge 34, so the issue interval is 34 cycles.
- Divide by zero:
  - HI/LO written at edge 0.
  - DONE occupies edge 0 to edge 1; Done=1 in that cycle.
  - Busy never asserts.
- HI/LO are stable and combinationally visible at all times except at their write edges. MFHI/MFLO read them without waiting.
- Reset asserted mid-operation:
  - Aborts immediately; no partial result is written.
  - All outputs take their reset values asynchronously.
  - The first Start after reset deassertion is accepted normally.

## Test plan

- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> Done at edge 34 after Start, HI=0xFFFFFFFE, LO=0x00000001; Busy high for exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) * 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100 / 0 -> Done the cycle after launch, Busy stays 0, LO=0xFFFFFFFF, HI=0x00000064.
- Stimulus: Start a MULTU of 3*4. At cycle 10, pulse Start with new operands and Write_LO=1 (Read_data1=0x1234). Response: both pulses ignored; result HI=0, LO=12. Then Write_LO=1 while idle -> LO=0x1234 next edge.
- Reset at cycle 15 of a DIV -> HI=LO=0, Busy=0, Done=0 immediately. A following MULTU 2*2 -> LO=4 after 34 cycles. Start held high through DONE -> second result at edge 68.
